// File: rtl/wb_merge_buffer.sv
// Write-back merge buffer: combines ALU pipe A, ALU pipe B and load returns
// onto the two write ports of the register file. Loads that cannot get a
// port are held in an in-order FIFO. A younger ALU write to the same
// register kills an older load, so that stale load data can never overwrite
// the newer ALU result.
module wb_merge_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int REG_AW = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          a_valid,
  input  logic [REG_AW-1:0]             a_dest,
  input  logic [DATA_W-1:0]             a_data,
  input  logic                          b_valid,
  input  logic [REG_AW-1:0]             b_dest,
  input  logic [DATA_W-1:0]             b_data,
  input  logic                          ld_valid,
  input  logic [REG_AW-1:0]             ld_dest,
  input  logic [DATA_W-1:0]             ld_data,
  output logic                          ld_ready,
  output logic                          regWrite1,
  output logic [REG_AW-1:0]             destReg1,
  output logic [DATA_W-1:0]             writeData1,
  output logic                          regWrite2,
  output logic [REG_AW-1:0]             destReg2,
  output logic [DATA_W-1:0]             writeData2,
  output logic [(1<<REG_AW)-1:0]        pend_mask,
  output logic [$clog2(DEPTH+1)-1:0]    fifo_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int NR = 1 << REG_AW;

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_TWO  = CW'(2);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  // An ALU result to register d in this cycle makes any load to d stale.
  function automatic logic alu_hit(
    input logic              av,
    input logic [REG_AW-1:0] ad,
    input logic              bv,
    input logic [REG_AW-1:0] bd,
    input logic [REG_AW-1:0] d
  );
    alu_hit = (av && (ad == d)) || (bv && (bd == d));
  endfunction

  // FIFO storage and control state
  logic [REG_AW-1:0] dest_mem_r [DEPTH];
  logic [DATA_W-1:0] data_mem_r [DEPTH];
  logic [DEPTH-1:0]  kill_r;
  logic [PW-1:0]     head_r;
  logic [PW-1:0]     tail_r;
  logic [CW-1:0]     count_r;
  logic [NR-1:0]     pend_r;

  // Registered write-port outputs
  logic              we1_r;
  logic [REG_AW-1:0] dst1_r;
  logic [DATA_W-1:0] wd1_r;
  logic              we2_r;
  logic [REG_AW-1:0] dst2_r;
  logic [DATA_W-1:0] wd2_r;

  // Combinational intermediates
  logic              ld_ready_s;
  logic              ld_acc_s;
  logic              inc_kill_s;
  logic [PW-1:0]     head1_s;
  logic [1:0]        src_v_s;
  logic [1:0]        src_k_s;
  logic [REG_AW-1:0] src_d_s [2];
  logic [DATA_W-1:0] src_w_s [2];
  logic              p1_use_s;
  logic              p2_sel_s;
  logic              p2_use_s;
  logic [1:0]        n_used_s;
  logic [1:0]        n_fifo_s;
  logic [1:0]        pops_s;
  logic              bypass_s;
  logic              push_s;
  logic [REG_AW-1:0] dest_n_s [DEPTH];
  logic [DATA_W-1:0] data_n_s [DEPTH];
  logic [DEPTH-1:0]  kill_n_s;
  logic [PW-1:0]     head_n_s;
  logic [PW-1:0]     tail_n_s;
  logic [CW-1:0]     count_n_s;
  logic [NR-1:0]     pend_n_s;
  logic [PW-1:0]     scan_idx_s;
  logic              we1_n_s;
  logic [REG_AW-1:0] dst1_n_s;
  logic [DATA_W-1:0] wd1_n_s;
  logic              we2_n_s;
  logic [REG_AW-1:0] dst2_n_s;
  logic [DATA_W-1:0] wd2_n_s;

  assign ld_ready_s = (count_r != CNT_FULL);
  assign ld_ready   = ld_ready_s;
  assign ld_acc_s   = ld_valid && ld_ready_s;
  assign inc_kill_s = alu_hit(a_valid, a_dest, b_valid, b_dest, ld_dest);
  assign head1_s    = head_r + PTR_ONE;

  // Build the two oldest load candidates: FIFO head, next entry, then the incoming load.
  always_comb begin
    src_v_s    = 2'b00;
    src_k_s    = 2'b00;
    src_d_s[0] = '0;
    src_w_s[0] = '0;
    src_d_s[1] = '0;
    src_w_s[1] = '0;
    if (count_r >= CNT_ONE) begin
      src_v_s[0] = 1'b1;
      src_d_s[0] = dest_mem_r[head_r];
      src_w_s[0] = data_mem_r[head_r];
      src_k_s[0] = kill_r[head_r] |
                   alu_hit(a_valid, a_dest, b_valid, b_dest, dest_mem_r[head_r]);
    end else if (ld_acc_s) begin
      src_v_s[0] = 1'b1;
      src_d_s[0] = ld_dest;
      src_w_s[0] = ld_data;
      src_k_s[0] = inc_kill_s;
    end else begin
      src_v_s[0] = 1'b0;
    end
    if (count_r >= CNT_TWO) begin
      src_v_s[1] = 1'b1;
      src_d_s[1] = dest_mem_r[head1_s];
      src_w_s[1] = data_mem_r[head1_s];
      src_k_s[1] = kill_r[head1_s] |
                   alu_hit(a_valid, a_dest, b_valid, b_dest, dest_mem_r[head1_s]);
    end else if ((count_r == CNT_ONE) && ld_acc_s) begin
      src_v_s[1] = 1'b1;
      src_d_s[1] = ld_dest;
      src_w_s[1] = ld_data;
      src_k_s[1] = inc_kill_s;
    end else begin
      src_v_s[1] = 1'b0;
    end
  end

  // Hand free ports to load candidates port-1-first and work out pop/push/bypass.
  always_comb begin
    p1_use_s = !a_valid && src_v_s[0];
    p2_sel_s = !a_valid;
    p2_use_s = !b_valid && src_v_s[p2_sel_s];
    n_used_s = {1'b0, p1_use_s} + {1'b0, p2_use_s};
    if (count_r >= CNT_TWO) begin
      n_fifo_s = 2'd2;
    end else begin
      n_fifo_s = count_r[1:0];
    end
    if (n_used_s < n_fifo_s) begin
      pops_s = n_used_s;
    end else begin
      pops_s = n_fifo_s;
    end
    // The incoming load used a port only when every buffered entry drained ahead of it.
    bypass_s = ld_acc_s && (CW'(n_used_s) > count_r);
    push_s   = ld_acc_s && !bypass_s;
  end

  // Next FIFO contents: apply this cycle's kills, then write the pushed entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if (push_s && (tail_r == PW'(i))) begin
        dest_n_s[i] = ld_dest;
        data_n_s[i] = ld_data;
        kill_n_s[i] = inc_kill_s;
      end else begin
        dest_n_s[i] = dest_mem_r[i];
        data_n_s[i] = data_mem_r[i];
        kill_n_s[i] = kill_r[i] |
                      alu_hit(a_valid, a_dest, b_valid, b_dest, dest_mem_r[i]);
      end
    end
    head_n_s  = head_r + PW'(pops_s);
    tail_n_s  = tail_r + PW'(push_s);
    count_n_s = count_r - CW'(pops_s) + CW'(push_s);
  end

  // Pending mask over the live entries that remain after this edge.
  always_comb begin
    pend_n_s   = '0;
    scan_idx_s = head_n_s;
    for (int k = 0; k < DEPTH; k++) begin
      scan_idx_s = head_n_s + PW'(k);
      pend_n_s[dest_n_s[scan_idx_s]] = pend_n_s[dest_n_s[scan_idx_s]] |
        ((CW'(k) < count_n_s) && !kill_n_s[scan_idx_s]);
    end
  end

  // Next write-port values: ALU pipes own their port, loads fill the rest.
  always_comb begin
    if (a_valid) begin
      we1_n_s  = 1'b1;
      dst1_n_s = a_dest;
      wd1_n_s  = a_data;
    end else if (p1_use_s) begin
      we1_n_s  = !src_k_s[0];
      dst1_n_s = src_d_s[0];
      wd1_n_s  = src_w_s[0];
    end else begin
      we1_n_s  = 1'b0;
      dst1_n_s = dst1_r;
      wd1_n_s  = wd1_r;
    end
    if (b_valid) begin
      we2_n_s  = 1'b1;
      dst2_n_s = b_dest;
      wd2_n_s  = b_data;
    end else if (p2_use_s) begin
      we2_n_s  = !src_k_s[p2_sel_s];
      dst2_n_s = src_d_s[p2_sel_s];
      wd2_n_s  = src_w_s[p2_sel_s];
    end else begin
      we2_n_s  = 1'b0;
      dst2_n_s = dst2_r;
      wd2_n_s  = wd2_r;
    end
  end

  // FIFO state register; reset discards every buffered load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem_r[i] <= '0;
        data_mem_r[i] <= '0;
      end
      kill_r  <= '0;
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
      pend_r  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        dest_mem_r[i] <= dest_n_s[i];
        data_mem_r[i] <= data_n_s[i];
      end
      kill_r  <= kill_n_s;
      head_r  <= head_n_s;
      tail_r  <= tail_n_s;
      count_r <= count_n_s;
      pend_r  <= pend_n_s;
    end
  end

  // Write-port output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we1_r  <= 1'b0;
      dst1_r <= '0;
      wd1_r  <= '0;
      we2_r  <= 1'b0;
      dst2_r <= '0;
      wd2_r  <= '0;
    end else begin
      we1_r  <= we1_n_s;
      dst1_r <= dst1_n_s;
      wd1_r  <= wd1_n_s;
      we2_r  <= we2_n_s;
      dst2_r <= dst2_n_s;
      wd2_r  <= wd2_n_s;
    end
  end

  assign regWrite1  = we1_r;
  assign destReg1   = dst1_r;
  assign writeData1 = wd1_r;
  assign regWrite2  = we2_r;
  assign destReg2   = dst2_r;
  assign writeData2 = wd2_r;
  assign pend_mask  = pend_r;
  assign fifo_count = count_r;

endmodule

// File: tb/tb_wb_merge_buffer.sv
// Self-checking bench for wb_merge_buffer: expected register-file writes are
// queued as stimulus is driven and compared as the write ports fire.
module tb_wb_merge_buffer;

  logic        clk;
  logic        reset;
  logic        a_valid;
  logic [2:0]  a_dest;
  logic [31:0] a_data;
  logic        b_valid;
  logic [2:0]  b_dest;
  logic [31:0] b_data;
  logic        ld_valid;
  logic [2:0]  ld_dest;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        regWrite1;
  logic [2:0]  destReg1;
  logic [31:0] writeData1;
  logic        regWrite2;
  logic [2:0]  destReg2;
  logic [31:0] writeData2;
  logic [7:0]  pend_mask;
  logic [2:0]  fifo_count;

  typedef struct packed {
    logic [1:0]  port;
    logic [2:0]  dest;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  wb_merge_buffer #(.DEPTH(4), .DATA_W(32), .REG_AW(3)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_dest(a_dest), .a_data(a_data),
    .b_valid(b_valid), .b_dest(b_dest), .b_data(b_data),
    .ld_valid(ld_valid), .ld_dest(ld_dest), .ld_data(ld_data),
    .ld_ready(ld_ready),
    .regWrite1(regWrite1), .destReg1(destReg1), .writeData1(writeData1),
    .regWrite2(regWrite2), .destReg2(destReg2), .writeData2(writeData2),
    .pend_mask(pend_mask), .fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void expect_wr(input int p, input logic [2:0] d, input logic [31:0] x);
    wr_t e;
    e.port = p[1:0];
    e.dest = d;
    e.data = x;
    exp_q.push_back(e);
  endfunction

  // Scoreboard: every write the ports perform must be the next expected one.
  always @(negedge clk) begin
    if (!reset) begin
      if (regWrite1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL port1_write: got dest=%0d data=%h, expected no write", destReg1, writeData1);
        end else begin
          mon_e = exp_q.pop_front();
          if ({2'd1, destReg1, writeData1} !== mon_e) begin
            n_bad++;
            $display("FAIL port1_write: got port1 dest=%0d data=%h, expected port%0d dest=%0d data=%h",
                     destReg1, writeData1, mon_e.port, mon_e.dest, mon_e.data);
          end
        end
      end
      if (regWrite2) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL port2_write: got dest=%0d data=%h, expected no write", destReg2, writeData2);
        end else begin
          mon_e = exp_q.pop_front();
          if ({2'd2, destReg2, writeData2} !== mon_e) begin
            n_bad++;
            $display("FAIL port2_write: got port2 dest=%0d data=%h, expected port%0d dest=%0d data=%h",
                     destReg2, writeData2, mon_e.port, mon_e.dest, mon_e.data);
          end
        end
      end
    end
  end

  task automatic idle();
    a_valid = 1'b0; a_dest = 3'd0; a_data = 32'h0;
    b_valid = 1'b0; b_dest = 3'd0; b_data = 32'h0;
    ld_valid = 1'b0; ld_dest = 3'd0; ld_data = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic [2:0] d, input logic [31:0] x);
    a_valid = 1'b1; a_dest = d; a_data = x;
  endtask

  task automatic drive_b(input logic [2:0] d, input logic [31:0] x);
    b_valid = 1'b1; b_dest = d; b_data = x;
  endtask

  task automatic drive_ld(input logic [2:0] d, input logic [31:0] x);
    ld_valid = 1'b1; ld_dest = d; ld_data = x;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if ({regWrite1, regWrite2, destReg1, destReg2, writeData1, writeData2} !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_ports: got we=%b%b d=%0d/%0d, required all zero", regWrite1, regWrite2, destReg1, destReg2);
    end
    n_cmp++;
    if ({fifo_count, pend_mask, ld_ready} !== 12'h001) begin
      n_bad++;
      $display("FAIL reset_state: got count=%0d pend=%h rdy=%b, required 0/00/1", fifo_count, pend_mask, ld_ready);
    end
    step();
    reset = 1'b0;
    step();
    n_cmp++;
    if ({regWrite1, regWrite2, fifo_count} !== 5'h0) begin
      n_bad++;
      $display("FAIL after_reset: got we=%b%b count=%0d, required 0 0 0", regWrite1, regWrite2, fifo_count);
    end
  endtask

  task automatic test_alu_load();
    drive_a(3'd2, 32'h11);
    drive_ld(3'd5, 32'h55);
    expect_wr(1, 3'd2, 32'h11);
    expect_wr(2, 3'd5, 32'h55);
    step();
    idle();
    n_cmp++;
    if ({regWrite1, destReg1, writeData1, regWrite2, destReg2, writeData2, fifo_count} !==
        {1'b1, 3'd2, 32'h11, 1'b1, 3'd5, 32'h55, 3'd0}) begin
      n_bad++;
      $display("FAIL alu_load: got p1=(%b,%0d,%h) p2=(%b,%0d,%h) count=%0d, required p1=(1,2,11) p2=(1,5,55) count=0",
               regWrite1, destReg1, writeData1, regWrite2, destReg2, writeData2, fifo_count);
    end
    step();
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive_a(3'd0, 32'hA0 + i);
      drive_b(3'd7, 32'hB0 + i);
      drive_ld(3'(i + 1), 32'h1000 + i + 1);
      expect_wr(1, 3'd0, 32'hA0 + i);
      expect_wr(2, 3'd7, 32'hB0 + i);
      step();
      n_cmp++;
      if (fifo_count !== 3'(i + 1)) begin
        n_bad++;
        $display("FAIL fill_count: got %0d, required %0d", fifo_count, i + 1);
      end
    end
    n_cmp++;
    if (ld_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_ready: got %b, required 0", ld_ready);
    end
    drive_a(3'd0, 32'hA4);
    drive_b(3'd7, 32'hB4);
    drive_ld(3'd5, 32'h1005);
    expect_wr(1, 3'd0, 32'hA4);
    expect_wr(2, 3'd7, 32'hB4);
    step();
    n_cmp++;
    if ({fifo_count, pend_mask} !== {3'd4, 8'h1E}) begin
      n_bad++;
      $display("FAIL fill_full: got count=%0d pend=%h, required 4/1e", fifo_count, pend_mask);
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    expect_wr(1, 3'd1, 32'h1001);
    expect_wr(2, 3'd2, 32'h1002);
    step();
    n_cmp++;
    if ({destReg1, destReg2, fifo_count, ld_ready} !== {3'd1, 3'd2, 3'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL fill_drain1: got d=%0d/%0d count=%0d rdy=%b, required 1/2 2 1", destReg1, destReg2, fifo_count, ld_ready);
    end
    expect_wr(1, 3'd3, 32'h1003);
    expect_wr(2, 3'd4, 32'h1004);
    step();
    ld_valid = 1'b0;
    n_cmp++;
    if ({destReg1, destReg2, fifo_count, pend_mask} !== {3'd3, 3'd4, 3'd1, 8'h20}) begin
      n_bad++;
      $display("FAIL fill_drain2: got d=%0d/%0d count=%0d pend=%h, required 3/4 1 20", destReg1, destReg2, fifo_count, pend_mask);
    end
    expect_wr(1, 3'd5, 32'h1005);
    step();
    n_cmp++;
    if ({fifo_count, pend_mask} !== {3'd0, 8'h00}) begin
      n_bad++;
      $display("FAIL fill_empty: got count=%0d pend=%h, required 0/00", fifo_count, pend_mask);
    end
    step();
  endtask

  task automatic test_kill();
    drive_a(3'd0, 32'hC0);
    drive_b(3'd6, 32'hD0);
    drive_ld(3'd3, 32'hAA);
    expect_wr(1, 3'd0, 32'hC0);
    expect_wr(2, 3'd6, 32'hD0);
    step();
    n_cmp++;
    if ({fifo_count, pend_mask} !== {3'd1, 8'h08}) begin
      n_bad++;
      $display("FAIL kill_buffered: got count=%0d pend=%h, required 1/08", fifo_count, pend_mask);
    end
    ld_valid = 1'b0;
    drive_a(3'd3, 32'hBB);
    drive_b(3'd6, 32'hD1);
    expect_wr(1, 3'd3, 32'hBB);
    expect_wr(2, 3'd6, 32'hD1);
    step();
    idle();
    n_cmp++;
    if ({regWrite1, destReg1, writeData1, pend_mask, fifo_count} !== {1'b1, 3'd3, 32'hBB, 8'h00, 3'd1}) begin
      n_bad++;
      $display("FAIL kill_mark: got p1=(%b,%0d,%h) pend=%h count=%0d, required (1,3,bb) 00 1",
               regWrite1, destReg1, writeData1, pend_mask, fifo_count);
    end
    step();
    n_cmp++;
    if ({regWrite1, regWrite2, fifo_count} !== 5'h0) begin
      n_bad++;
      $display("FAIL kill_pop: got we=%b%b count=%0d, required 0 0 0", regWrite1, regWrite2, fifo_count);
    end
    step();
  endtask

  task automatic test_same_dest();
    drive_a(3'd4, 32'h40);
    drive_b(3'd4, 32'h41);
    expect_wr(1, 3'd4, 32'h40);
    expect_wr(2, 3'd4, 32'h41);
    step();
    idle();
    n_cmp++;
    if ({regWrite1, destReg1, writeData1, regWrite2, destReg2, writeData2} !==
        {1'b1, 3'd4, 32'h40, 1'b1, 3'd4, 32'h41}) begin
      n_bad++;
      $display("FAIL same_dest: got p1=(%b,%0d,%h) p2=(%b,%0d,%h), required (1,4,40) (1,4,41)",
               regWrite1, destReg1, writeData1, regWrite2, destReg2, writeData2);
    end
    step();
  endtask

  task automatic test_full_push_pop();
    logic [2:0] dl [4];
    dl[0] = 3'd1; dl[1] = 3'd2; dl[2] = 3'd3; dl[3] = 3'd5;
    for (int i = 0; i < 4; i++) begin
      drive_a(3'd0, 32'hF0 + i);
      drive_b(3'd7, 32'hF8 + i);
      drive_ld(dl[i], 32'h201 + i);
      expect_wr(1, 3'd0, 32'hF0 + i);
      expect_wr(2, 3'd7, 32'hF8 + i);
      step();
    end
    n_cmp++;
    if ({fifo_count, ld_ready} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL full_state: got count=%0d rdy=%b, required 4 0", fifo_count, ld_ready);
    end
    b_valid = 1'b0;
    drive_a(3'd0, 32'hE0);
    drive_ld(3'd6, 32'h206);
    expect_wr(1, 3'd0, 32'hE0);
    expect_wr(2, 3'd1, 32'h201);
    step();
    n_cmp++;
    if ({regWrite2, destReg2, fifo_count, ld_ready} !== {1'b1, 3'd1, 3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL full_pop: got p2=(%b,%0d) count=%0d rdy=%b, required (1,1) 3 1", regWrite2, destReg2, fifo_count, ld_ready);
    end
    drive_a(3'd0, 32'hE1);
    expect_wr(1, 3'd0, 32'hE1);
    expect_wr(2, 3'd2, 32'h202);
    step();
    idle();
    n_cmp++;
    if ({destReg2, fifo_count, pend_mask} !== {3'd2, 3'd3, 8'h68}) begin
      n_bad++;
      $display("FAIL push_pop: got d2=%0d count=%0d pend=%h, required 2 3 68", destReg2, fifo_count, pend_mask);
    end
    expect_wr(1, 3'd3, 32'h203);
    expect_wr(2, 3'd5, 32'h204);
    step();
    n_cmp++;
    if ({fifo_count, pend_mask} !== {3'd1, 8'h40}) begin
      n_bad++;
      $display("FAIL full_drain: got count=%0d pend=%h, required 1 40", fifo_count, pend_mask);
    end
    expect_wr(1, 3'd6, 32'h206);
    step();
    step();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive_a(3'd0, 32'h300 + i);
      drive_b(3'd7, 32'h310 + i);
      drive_ld(3'(i + 1), 32'h3A0 + i);
      expect_wr(1, 3'd0, 32'h300 + i);
      expect_wr(2, 3'd7, 32'h310 + i);
      step();
    end
    n_cmp++;
    if (fifo_count !== 3'd3) begin
      n_bad++;
      $display("FAIL mid_fill: got count=%0d, required 3", fifo_count);
    end
    ld_valid = 1'b0;
    drive_a(3'd0, 32'h3F0);
    drive_b(3'd7, 32'h3F1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({regWrite1, regWrite2, fifo_count, pend_mask, ld_ready} !== {2'b00, 3'd0, 8'h00, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset_async: got we=%b%b count=%0d pend=%h rdy=%b, required 0 0 0 00 1",
               regWrite1, regWrite2, fifo_count, pend_mask, ld_ready);
    end
    step();
    reset = 1'b0;
    idle();
    repeat (4) step();
    n_cmp++;
    if ({regWrite1, regWrite2, fifo_count, pend_mask} !== {2'b00, 3'd0, 8'h00}) begin
      n_bad++;
      $display("FAIL mid_reset_after: got we=%b%b count=%0d pend=%h, required 0 0 0 00",
               regWrite1, regWrite2, fifo_count, pend_mask);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_alu_load();
    test_fill();
    test_kill();
    test_same_dest();
    test_full_push_pop();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
